// File: rtl/mips_prog_loader.sv
// mips_prog_loader
// Loads a program image into instruction memory from a byte stream while
// holding the processor in reset. Bytes arrive MSB-first, four per word;
// each assembled word is written at base_addr + words_loaded. Loading stops
// after word_count words, or early when an HLT word (opcode 6'h3f) is written.
//
// state | meaning
// IDLE  | waiting for start; start with word_count==0 goes straight to DONE
// RECV  | accepting bytes (in_ready=1) into the word assembly register
// WRITE | one-cycle memory write of the assembled word
// DONE  | one-cycle done pulse, processor released
//
// Ports
//   clk1          single clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         load request, only honoured in IDLE
//   base_addr     first word address, captured on accepted start
//   word_count    number of words to load, captured on accepted start
//   in_valid      byte stream valid
//   in_data       byte stream data
//   in_ready      byte stream ready (RECV only)
//   mem_we        instruction memory write strobe
//   mem_addr      instruction memory word address
//   mem_wdata     instruction memory write data
//   busy          high whenever not IDLE
//   done          one-cycle completion pulse
//   hlt_seen      an HLT word was loaded, sticky until next accepted start
//   cpu_hold      keeps the processor halted while memory content is invalid
//   words_loaded  words written during the current load
module mips_prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              hlt_seen,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] words_loaded
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [1:0]        byte_idx;
  logic [23:0]       shift_q;   // first three bytes; the fourth is merged on the fly
  logic [ADDR_W-1:0] loaded_next;
  logic              word_is_hlt;

  assign loaded_next = words_loaded + {{(ADDR_W-1){1'b0}}, 1'b1};
  // mem_wdata holds the word being written while in WRITE
  assign word_is_hlt = (mem_wdata[31:26] == 6'h3f);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base_q       <= '0;
      count_q      <= '0;
      byte_idx     <= 2'd0;
      shift_q      <= '0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      hlt_seen     <= 1'b0;
      cpu_hold     <= 1'b1;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (word_count != '0) begin
              base_q       <= base_addr;
              count_q      <= word_count;
              words_loaded <= '0;
              byte_idx     <= 2'd0;
              hlt_seen     <= 1'b0;
              cpu_hold     <= 1'b1;
              in_ready     <= 1'b1;
              state        <= RECV;
            end else begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= DONE;
            end
          end
        end
        RECV: begin
          if (in_valid && in_ready) begin
            shift_q  <= {shift_q[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_addr  <= base_q + words_loaded;
              mem_wdata <= {shift_q, in_data};
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          mem_we       <= 1'b0;
          words_loaded <= loaded_next;
          if (word_is_hlt) hlt_seen <= 1'b1;
          if (loaded_next == count_q || word_is_hlt) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= RECV;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: the stimulus side predicts the
// memory writes and done pulses of each load from the loading rules and
// queues them; a negedge monitor pops and compares as the DUT produces them.
module tb_mips_prog_loader;
  localparam int AW = 10;

  logic          clk1 = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] word_count;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          hlt_seen;
  logic          cpu_hold;
  logic [AW-1:0] words_loaded;

  mips_prog_loader #(.ADDR_W(AW)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .hlt_seen(hlt_seen),
    .cpu_hold(cpu_hold), .words_loaded(words_loaded)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  bit  exp_done_q[$];   // 1: done must follow a write in the previous cycle
  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  bit  last_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk1) begin
    if (!rst_n) begin
      last_we = 1'b0;
    end else begin
      if (mem_we) begin
        checks++;
        if (last_we) begin
          errors++;
          $display("FAIL back_to_back_write actual=consecutive required=gap");
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual=%h@%h required=none", mem_wdata, mem_addr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data) begin
            errors++;
            $display("FAIL write actual=%h@%h required=%h@%h", mem_wdata, mem_addr, e.data, e.addr);
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          bit need_we;
          need_we = exp_done_q.pop_front();
          if (need_we && !last_we) begin
            errors++;
            $display("FAIL done_latency actual=no_write_prev_cycle required=write_prev_cycle");
          end
          if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL done_early actual=%0d_writes_pending required=0", exp_q.size());
          end
        end
        done_cnt++;
      end
      last_we = mem_we;
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    @(posedge clk1); #1;
    start = 1'b0; base_addr = $urandom; word_count = $urandom;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_pct);
    for (int b = 3; b >= 0; b--) begin
      bit acc;
      int waited;
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk1);
        #1;
      end
      in_valid = 1'b1;
      in_data  = w[8*b +: 8];
      acc = 1'b0;
      waited = 0;
      while (!acc && waited < 50) begin
        @(negedge clk1);
        acc = in_ready;
        @(posedge clk1); #1;
        waited++;
      end
      in_valid = 1'b0;
      in_data  = $urandom;
      if (!acc) begin
        checks++; errors++;
        $display("FAIL byte_accept_timeout actual=not_ready required=ready");
        return;
      end
    end
  endtask

  task automatic wait_done();
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(posedge clk1);
      if (done_cnt != d0) seen = 1'b1;
    end
    #1;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  // Reference: words are written at consecutive addresses (mod 2^AW) until
  // word_count words are written or an HLT (top six bits all ones) is written.
  task automatic run_load(input logic [AW-1:0] b, input logic [AW-1:0] c,
                          input logic [31:0] words[$], input int gap_pct);
    int  n;
    bit  hlt;
    n = 0;
    hlt = 1'b0;
    for (int i = 0; i < int'(c) && !hlt && i < words.size(); i++) begin
      wr_t e;
      e.addr = AW'((int'(b) + i) % (1 << AW));
      e.data = words[i];
      exp_q.push_back(e);
      n++;
      if (words[i][31:26] == 6'h3f) hlt = 1'b1;
    end
    exp_done_q.push_back(c != 0);
    do_start(b, c);
    for (int i = 0; i < n; i++) send_word(words[i], gap_pct);
    wait_done();
    check("words_loaded", 32'(words_loaded), 32'(n));
    check("hlt_seen", 32'(hlt_seen), 32'(hlt));
    check("cpu_hold_after", 32'(cpu_hold), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] fact[$];
    logic [31:0] ws[$];
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk1);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cpu_hold", 32'(cpu_hold), 1);
    check("rst_words_loaded", 32'(words_loaded), 0);
    rst_n = 1'b1;
    @(posedge clk1); #1;

    // Factorial image
    fact = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000,
             32'h14431000, 32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe,
             32'hfc000000};
    run_load(10'd0, 10'd11, fact, 0);

    // Early HLT: extra bytes must not be taken
    ws = '{32'h280a00c8, 32'h28020001, 32'hfc000000, 32'h12345678, 32'h9abcdef0};
    run_load(10'd50, 10'd20, ws, 0);
    in_valid = 1'b1; in_data = 8'haa;
    repeat (5) begin
      @(negedge clk1);
      check("in_ready_post_hlt", 32'(in_ready), 0);
    end
    @(posedge clk1); #1;
    in_valid = 1'b0;

    // Back-pressure: same image with and without gaps
    ws = '{32'h28020001, 32'h0e94a000};
    run_load(10'd100, 10'd2, ws, 0);
    run_load(10'd100, 10'd2, ws, 70);

    // Address wrap
    ws = '{32'h11112222, 32'h33334444};
    run_load(10'd1023, 10'd2, ws, 30);

    // Random loads
    for (int r = 0; r < 4; r++) begin
      int c;
      c = $urandom_range(1, 5);
      ws.delete();
      for (int i = 0; i < c; i++) ws.push_back($urandom);
      run_load(AW'($urandom_range(1023)), AW'(c), ws, $urandom_range(0, 60));
    end

    // Reset after two bytes of the first word
    do_start(10'd0, 10'd5);
    in_valid = 1'b1; in_data = 8'h11;
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_cpu_hold", 32'(cpu_hold), 1);
    check("midrst_mem_addr", 32'(mem_addr), 0);
    check("midrst_mem_wdata", mem_wdata, 0);
    @(posedge clk1); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk1);
    #1;
    in_valid = 1'b0;
    check("post_rst_hold", 32'(cpu_hold), 1);
    ws = '{32'h00000007};
    run_load(10'd200, 10'd1, ws, 0);

    // Zero-count start: done on the next cycle, no writes
    exp_done_q.push_back(1'b0);
    do_start(10'd300, 10'd0);
    check("zero_count_done", 32'(done), 1);
    wait_done();
    check("zero_count_busy", 32'(busy), 0);
    repeat (3) @(posedge clk1);
    check("pending_writes", 32'(exp_q.size()), 0);
    check("pending_dones", 32'(exp_done_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
